// File: rtl/mac_pipe_param_if.sv
// Sample/result bus for mac_pipe_param: a ready/valid input side carrying operands and
// per-sample control, and a ready/valid output side carrying the result and the overflow flag.
interface mac_pipe_param_if #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned OUT_WIDTH = 20
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     A;
   logic [WIDTH-1:0]     B;
   logic [WIDTH-1:0]     C;
   logic                 mode;
   logic                 acc_clr;
   logic                 out_valid;
   logic                 out_ready;
   logic [OUT_WIDTH-1:0] DATA_OUT;
   logic                 ovf;

   // Producer/consumer side that feeds samples and takes results
   modport master (
      output in_valid, A, B, C, mode, acc_clr, out_ready,
      input  in_ready, out_valid, DATA_OUT, ovf
   );

   // MAC side
   modport slave (
      input  in_valid, A, B, C, mode, acc_clr, out_ready,
      output in_ready, out_valid, DATA_OUT, ovf
   );
endinterface

// File: rtl/mac_pipe_param.sv
// Three-stage multiply-accumulate pipeline with a single global enable driven by output
// backpressure. Mode 0 yields A*B+C; mode 1 accumulates A*B with a sticky overflow flag.
// Build option: define MAC_SAT_EN to clamp the accumulator at its maximum on overflow
// instead of wrapping. OUT_WIDTH must be at least 2*WIDTH+1.
module mac_pipe_param #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned OUT_WIDTH = 20
) (
   input logic             clk,
   input logic             rst,
   mac_pipe_param_if.slave bus
);
   localparam int unsigned PW = 2 * WIDTH;

   logic                 en;

   logic                 s1_valid;
   logic [WIDTH-1:0]     s1_a;
   logic [WIDTH-1:0]     s1_b;
   logic [WIDTH-1:0]     s1_c;
   logic                 s1_mode;
   logic                 s1_clr;

   logic                 s2_valid;
   logic [PW-1:0]        s2_prod;
   logic [WIDTH-1:0]     s2_c;
   logic                 s2_mode;
   logic                 s2_clr;

   logic                 out_valid;
   logic [OUT_WIDTH-1:0] data_out;
   logic [OUT_WIDTH-1:0] acc;
   logic                 ovf;

   logic [OUT_WIDTH-1:0] prod_ext;
   logic [OUT_WIDTH-1:0] c_ext;
   logic [OUT_WIDTH:0]   acc_sum;
   logic                 acc_carry;
   logic [OUT_WIDTH-1:0] acc_next;
   logic [OUT_WIDTH-1:0] data_next;
   logic                 ovf_next;

   // Whole pipe advances together whenever the output slot is free or being drained
   assign en           = !out_valid || bus.out_ready;
   assign bus.in_ready = en;

   assign bus.out_valid = out_valid;
   assign bus.DATA_OUT  = data_out;
   assign bus.ovf       = ovf;

   // S1: capture operands and per-sample control
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_c     <= '0;
         s1_mode  <= 1'b0;
         s1_clr   <= 1'b0;
      end else if (en) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_a    <= bus.A;
            s1_b    <= bus.B;
            s1_c    <= bus.C;
            s1_mode <= bus.mode;
            s1_clr  <= bus.acc_clr;
         end
      end
   end

   // S2: full-width product, delay the remaining fields alongside it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_prod  <= '0;
         s2_c     <= '0;
         s2_mode  <= 1'b0;
         s2_clr   <= 1'b0;
      end else if (en) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_prod <= PW'(s1_a) * PW'(s1_b);
            s2_c    <= s1_c;
            s2_mode <= s1_mode;
            s2_clr  <= s1_clr;
         end
      end
   end

   // S3 next state: mode-0 sum, accumulator restart, or accumulate with carry-out detect
   always_comb begin
      prod_ext  = OUT_WIDTH'(s2_prod);
      c_ext     = OUT_WIDTH'(s2_c);
      acc_sum   = {1'b0, acc} + {1'b0, prod_ext};
      acc_carry = acc_sum[OUT_WIDTH];
      acc_next  = acc;
      ovf_next  = ovf;
      data_next = data_out;
      if (!s2_mode) begin
         // Cannot overflow since OUT_WIDTH >= 2*WIDTH+1; accumulator untouched
         data_next = prod_ext + c_ext;
      end else if (s2_clr) begin
         acc_next  = prod_ext;
         ovf_next  = 1'b0;
         data_next = prod_ext;
      end else begin
         ovf_next = ovf | acc_carry;
`ifdef MAC_SAT_EN
         // Once at the ceiling any nonzero product carries again, so the clamp persists
         acc_next = acc_carry ? {OUT_WIDTH{1'b1}} : acc_sum[OUT_WIDTH-1:0];
`else
         acc_next = acc_sum[OUT_WIDTH-1:0];
`endif
         data_next = acc_next;
      end
   end

   // S3: result register, accumulator and sticky overflow; bubbles leave them alone
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         data_out  <= '0;
         acc       <= '0;
         ovf       <= 1'b0;
      end else if (en) begin
         out_valid <= s2_valid;
         if (s2_valid) begin
            data_out <= data_next;
            acc      <= acc_next;
            ovf      <= ovf_next;
         end
      end
   end
endmodule

// File: tb/tb_mac_pipe_param.sv
// Directed self-checking bench for mac_pipe_param (WIDTH=8, OUT_WIDTH=20).
// Build with MAC_SAT_EN defined to expect the saturating overflow result.
module tb_mac_pipe_param;
   localparam int unsigned WIDTH     = 8;
   localparam int unsigned OUT_WIDTH = 20;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   mac_pipe_param_if #(.WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus ();

   mac_pipe_param #(.WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic m, input logic clr);
      bus.in_valid = v;
      bus.A        = a;
      bus.B        = b;
      bus.C        = c;
      bus.mode     = m;
      bus.acc_clr  = clr;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.out_ready = 1'b1;
      drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid);
      end
      total++;
      if (bus.DATA_OUT !== 20'd0) begin
         bad++; $display("FAIL reset_data: got %0d want 0", bus.DATA_OUT);
      end
      total++;
      if (bus.ovf !== 1'b0) begin
         bad++; $display("FAIL reset_ovf: got %0b want 0", bus.ovf);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++;
      if (bus.in_ready !== 1'b1) begin
         bad++; $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready);
      end
   endtask

   task automatic test_mode0();
      @(negedge clk);
      bus.out_ready = 1'b1;
      drive(1'b1, 8'd3, 8'd4, 8'd5, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         total++;
         if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL m0_early_valid%0d: got %0b want 0", i, bus.out_valid);
         end
         @(negedge clk);
      end
      total++;
      if (bus.out_valid !== 1'b1 || bus.DATA_OUT !== 20'd17) begin
         bad++; $display("FAIL m0_result: got valid=%0b data=%0d want valid=1 data=17",
                         bus.out_valid, bus.DATA_OUT);
      end
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++; $display("FAIL m0_one_cycle: got %0b want 0", bus.out_valid);
      end
   endtask

   // Mode-1 chain with a bubble and an interleaved mode-0 sample carrying a stray acc_clr
   task automatic test_accumulate();
      logic        vv [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [7:0]  av [5] = '{8'd2, 8'd9, 8'd4, 8'd1, 8'd1};
      logic [7:0]  bv [5] = '{8'd3, 8'd9, 8'd5, 8'd1, 8'd2};
      logic [7:0]  cv [5] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd0};
      logic        mv [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      logic        kv [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [19:0] ev [4] = '{20'd6, 20'd26, 20'd2, 20'd28};
      int k = 0;
      bus.out_ready = 1'b1;
      for (int cyc = 0; cyc < 15; cyc++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) begin
            total++;
            if (k >= 4) begin
               bad++; $display("FAIL acc_extra: got %0d want no result", bus.DATA_OUT);
            end else if (bus.DATA_OUT !== ev[k]) begin
               bad++; $display("FAIL acc_result%0d: got %0d want %0d", k, bus.DATA_OUT, ev[k]);
            end
            k++;
         end
         if (cyc < 5) drive(vv[cyc], av[cyc], bv[cyc], cv[cyc], mv[cyc], kv[cyc]);
         else drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
      end
      total++;
      if (k !== 4) begin
         bad++; $display("FAIL acc_count: got %0d want 4", k);
      end
   endtask

   // Consumer stalls for cycles 1..5 while four samples are offered
   task automatic test_backpressure();
      logic [19:0] ev [4] = '{20'd2, 20'd5, 20'd8, 20'd11};
      logic [19:0] held = '0;
      logic        held_ok = 1'b0;
      logic        exp_rdy;
      int sent = 0;
      int got  = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         @(negedge clk);
         bus.out_ready = !(cyc >= 1 && cyc <= 5);
         if (sent < 4) drive(1'b1, 8'(sent + 1), 8'd2, 8'(sent), 1'b0, 1'b0);
         else drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
         #1;
         exp_rdy = !(cyc >= 3 && cyc <= 5);
         total++;
         if (bus.in_ready !== exp_rdy) begin
            bad++; $display("FAIL bp_in_ready%0d: got %0b want %0b", cyc, bus.in_ready, exp_rdy);
         end
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b0) begin
            if (held_ok) begin
               total++;
               if (bus.DATA_OUT !== held) begin
                  bad++; $display("FAIL bp_hold%0d: got %0d want %0d", cyc, bus.DATA_OUT, held);
               end
            end
            held    = bus.DATA_OUT;
            held_ok = 1'b1;
         end else begin
            held_ok = 1'b0;
         end
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            total++;
            if (got >= 4) begin
               bad++; $display("FAIL bp_extra: got %0d want no result", bus.DATA_OUT);
            end else if (bus.DATA_OUT !== ev[got]) begin
               bad++; $display("FAIL bp_order%0d: got %0d want %0d", got, bus.DATA_OUT, ev[got]);
            end
            got++;
         end
         if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) sent++;
      end
      total++;
      if (got !== 4 || sent !== 4) begin
         bad++; $display("FAIL bp_count: got out=%0d in=%0d want 4 and 4", got, sent);
      end
   endtask

   // 17x(255*255) overflows, a (1,1) clear recovers, then a second run overflows again
   task automatic test_overflow();
      logic [19:0] sat_v;
      logic [19:0] ev;
      logic        eovf;
      int k = 0;
      int j;
`ifdef MAC_SAT_EN
      sat_v = 20'd1048575;
`else
      sat_v = 20'd56849;
`endif
      bus.out_ready = 1'b1;
      for (int cyc = 0; cyc < 45; cyc++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) begin
            if (k == 17) begin
               ev   = 20'd1;
               eovf = 1'b0;
            end else begin
               j    = (k < 17) ? k : k - 18;
               ev   = (j < 16) ? 20'((j + 1) * 65025) : sat_v;
               eovf = (j == 16);
            end
            total++;
            if (bus.DATA_OUT !== ev) begin
               bad++; $display("FAIL ovf_data%0d: got %0d want %0d", k, bus.DATA_OUT, ev);
            end
            total++;
            if (bus.ovf !== eovf) begin
               bad++; $display("FAIL ovf_flag%0d: got %0b want %0b", k, bus.ovf, eovf);
            end
            k++;
         end
         if (cyc < 17) drive(1'b1, 8'd255, 8'd255, 8'd0, 1'b1, cyc == 0);
         else if (cyc == 17) drive(1'b1, 8'd1, 8'd1, 8'd0, 1'b1, 1'b1);
         else if (cyc < 35) drive(1'b1, 8'd255, 8'd255, 8'd0, 1'b1, cyc == 18);
         else drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
      end
      total++;
      if (k !== 35) begin
         bad++; $display("FAIL ovf_count: got %0d want 35", k);
      end
   endtask

   // Reset mid-cycle with three samples in flight and ovf set from the previous test
   task automatic test_async_reset();
      total++;
      if (bus.ovf !== 1'b1) begin
         bad++; $display("FAIL ar_pre_ovf: got %0b want 1", bus.ovf);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      drive(1'b1, 8'd10, 8'd10, 8'd5, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 8'd2, 8'd2, 8'd2, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 8'd3, 8'd3, 8'd3, 1'b0, 1'b0);
      @(posedge clk);
      #3;
      total++;
      if (bus.out_valid !== 1'b1 || bus.DATA_OUT !== 20'd105) begin
         bad++; $display("FAIL ar_in_flight: got valid=%0b data=%0d want valid=1 data=105",
                         bus.out_valid, bus.DATA_OUT);
      end
      rst = 1'b1;
      drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
      #1;
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++; $display("FAIL ar_out_valid: got %0b want 0", bus.out_valid);
      end
      total++;
      if (bus.DATA_OUT !== 20'd0) begin
         bad++; $display("FAIL ar_data: got %0d want 0", bus.DATA_OUT);
      end
      total++;
      if (bus.ovf !== 1'b0) begin
         bad++; $display("FAIL ar_ovf: got %0b want 0", bus.ovf);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++;
      if (bus.in_ready !== 1'b1) begin
         bad++; $display("FAIL ar_in_ready: got %0b want 1", bus.in_ready);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         total++;
         if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL ar_ghost%0d: got %0b want 0", i, bus.out_valid);
         end
      end
      drive(1'b1, 8'd1, 8'd2, 8'd3, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1 || bus.DATA_OUT !== 20'd5) begin
         bad++; $display("FAIL ar_new_sample: got valid=%0b data=%0d want valid=1 data=5",
                         bus.out_valid, bus.DATA_OUT);
      end
   endtask

   initial begin
      test_reset();
      test_mode0();
      test_accumulate();
      test_backpressure();
      test_overflow();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/mac_pipe_param.md
MAC_PIPE_PARAM -- requirements
Module: mac_pipe_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width of A, B and C.
REQ-002 The block SHALL have parameter OUT_WIDTH, default 20, giving the result/accumulator width; legal only if OUT_WIDTH >= 2*WIDTH+1.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  input sample present
- in_ready  out  1  block can take a sample this cycle
- A, B, C  in  WIDTH each  unsigned operands
- mode  in  1  per-sample mode: 0 = A*B+C, 1 = accumulate A*B
- acc_clr  in  1  per-sample flag: restart accumulator with this sample
- out_valid  out  1  DATA_OUT holds a result
- out_ready  in  1  consumer takes the result this cycle
- DATA_OUT  out  OUT_WIDTH  result
- ovf  out  1  sticky accumulator overflow flag

Function
REQ-004 A sample SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-005 The pipeline SHALL have 3 stages: S1 registers A, B, C, mode and acc_clr; S2 registers A*B (2*WIDTH bits) and delays C, mode and acc_clr; S3 computes and registers DATA_OUT.
REQ-006 Pipeline enable SHALL be en = !out_valid || out_ready, and in_ready SHALL equal en (combinational).
REQ-007 When en=0, every stage, its valid bit, the accumulator and ovf SHALL hold.
REQ-008 With en=1 and no stalls, out_valid SHALL rise exactly 3 cycles after the accepting edge, and results SHALL leave in acceptance order.
REQ-009 Bubbles (in_valid=0) SHALL propagate as invalid stages and SHALL NOT alter the accumulator or ovf.
REQ-010 Mode 0 SHALL give DATA_OUT = A*B + C, zero-extended to OUT_WIDTH; it never overflows and SHALL NOT touch the accumulator or ovf.
REQ-011 Mode 1 with acc_clr=1 SHALL give acc = A*B and DATA_OUT = acc, and SHALL clear ovf in the same cycle.
REQ-012 Mode 1 with acc_clr=0 SHALL give acc = acc + A*B and DATA_OUT = acc.
REQ-013 Accumulator overflow SHALL be detected when the (OUT_WIDTH+1)-bit sum exceeds 2^OUT_WIDTH-1; ovf SHALL then be set and SHALL stay set until a mode-1 acc_clr sample or reset.
REQ-014 acc_clr SHALL be ignored on mode-0 samples.
REQ-015 Mode SHALL be switchable per sample; mode-0 samples interleaved between mode-1 samples SHALL leave the accumulator intact.
REQ-016 DATA_OUT SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-017 Asserting rst SHALL immediately clear all stage valid bits, out_valid, DATA_OUT, the accumulator and ovf to 0, regardless of the clock.
REQ-018 Samples in flight at reset SHALL be discarded and SHALL never appear at the output.
REQ-019 The first edge after rst deasserts SHALL be able to accept a sample (in_ready=1).

Configuration
REQ-020 Macro MAC_SAT_EN SHALL control overflow handling.
- Defined: on overflow, acc and DATA_OUT SHALL clamp to 2^OUT_WIDTH-1, and further mode-1 samples SHALL stay clamped until acc_clr.
- Undefined: acc and DATA_OUT SHALL wrap modulo 2^OUT_WIDTH.
- ovf SHALL behave identically in both builds.

Verification (WIDTH=8, OUT_WIDTH=20)
REQ-021 After reset, mode 0, A=3, B=4, C=5 for one cycle, out_ready=1 -> out_valid=1 exactly 3 cycles later with DATA_OUT=17 for one cycle.
REQ-022 Mode 1 sequence (2,3,clr=1), (4,5,clr=0), then mode 0 (1,1,C=1), then mode 1 (1,2,clr=0) -> outputs 6, 26, 2, 28.
REQ-023 out_ready=0 for 5 cycles while in_valid=1 with 4 distinct samples -> in_ready=0 whenever out_valid=1 and out_ready=0, DATA_OUT stable; after release all samples emerge in order, none lost or duplicated.
REQ-024 Mode 1, A=B=255 for 17 samples, first with clr=1 -> the 17th output is 56849 without MAC_SAT_EN or 1048575 with it, ovf=1 from that output onward; a following clr sample (1,1) -> DATA_OUT=1, ovf=0.
REQ-025 Assert rst asynchronously (mid-cycle) with 3 samples in flight -> out_valid, DATA_OUT and ovf go to 0 before the next edge, and no output appears after release until a new sample is accepted.
